// File: rtl/area_led_accum.sv
`default_nettype none
// ============================================================================
// Module   : area_led_accum
// Purpose  : Per-LED backlight colour averaging. Accumulates weighted RGB of
//            every block inside the LED's area over a frame, divides by the
//            total weight, and hands one RGB888 colour to the LED driver over
//            a valid/ready handshake.
// Option   : AREA_LED_HOLD_EN - a zero-weight frame keeps the previous
//            colour instead of forcing black.
// Revision : 1.0 - initial release
// ============================================================================
module area_led_accum #(
  parameter logic [2:0] W1     = 3'd4,
  parameter logic [2:0] W2     = 3'd2,
  parameter logic [2:0] W3     = 3'd1,
  parameter int         ACC_W  = 26,
  parameter int         WSUM_W = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [23:0] pix_data,
  input  logic        judge1,
  input  logic        judge2,
  input  logic        judge3,
  input  logic        frame_end,
  output logic        led_valid,
  input  logic        led_ready,
  output logic [23:0] led_rgb,
  output logic        zero_area
);

  // Remainder/divisor comparison width: enough for wsum shifted by 7
  localparam int DW = ACC_W + 8;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DIV   = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t              state;
  logic [3:0]          div_cnt;
  logic [ACC_W-1:0]    acc_r, acc_g, acc_b;
  logic [WSUM_W-1:0]   wsum;
  logic [7:0]          q_r, q_g, q_b;

  logic [2:0]          weight;
  logic [10:0]         prod_r, prod_g, prod_b;
  logic [2:0]          bit_idx;
  logic [DW-1:0]       divisor;
  logic                ge_r, ge_g, ge_b;
  logic [23:0]         zero_rgb;

  // Block weight from area membership, centre ring wins over outer rings
  always_comb begin
    weight = 3'd0;
    if (judge1)      weight = W1;
    else if (judge2) weight = W2;
    else if (judge3) weight = W3;
  end

  // Weighted channel products for the current block
  always_comb begin
    prod_r = {8'b0, weight} * {3'b0, pix_data[23:16]};
    prod_g = {8'b0, weight} * {3'b0, pix_data[15:8]};
    prod_b = {8'b0, weight} * {3'b0, pix_data[7:0]};
  end

  // Restoring-divide step: quotient bit 7 first; the accumulators double as
  // remainders since they are cleared after the result is consumed anyway
  always_comb begin
    bit_idx = 3'd7 - div_cnt[2:0];
    divisor = {{(DW-WSUM_W){1'b0}}, wsum} << bit_idx;
    ge_r    = {8'b0, acc_r} >= divisor;
    ge_g    = {8'b0, acc_g} >= divisor;
    ge_b    = {8'b0, acc_b} >= divisor;
  end

  // Colour presented when no block carried weight this frame
`ifdef AREA_LED_HOLD_EN
  always_comb zero_rgb = led_rgb;
`else
  always_comb zero_rgb = 24'h000000;
`endif

  // Frame controller: accumulate, divide, present, then restart
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ACCUM;
      div_cnt   <= 4'd0;
      acc_r     <= '0;
      acc_g     <= '0;
      acc_b     <= '0;
      wsum      <= '0;
      q_r       <= 8'd0;
      q_g       <= 8'd0;
      q_b       <= 8'd0;
      pix_ready <= 1'b1;
      led_valid <= 1'b0;
      led_rgb   <= 24'h000000;
      zero_area <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (pix_valid) begin
            acc_r <= acc_r + {{(ACC_W-11){1'b0}}, prod_r};
            acc_g <= acc_g + {{(ACC_W-11){1'b0}}, prod_g};
            acc_b <= acc_b + {{(ACC_W-11){1'b0}}, prod_b};
            wsum  <= wsum + {{(WSUM_W-3){1'b0}}, weight};
          end
          if (frame_end) begin
            state     <= ST_DIV;
            pix_ready <= 1'b0;
            div_cnt   <= 4'd0;
          end
        end

        ST_DIV: begin
          if (div_cnt == 4'd8) begin
            // Extra cycle after the 8 steps aligns the result with the
            // fixed frame_end-to-led_valid latency
            state     <= ST_OUT;
            led_valid <= 1'b1;
            zero_area <= (wsum == '0);
            led_rgb   <= (wsum == '0) ? zero_rgb : {q_r, q_g, q_b};
          end else begin
            div_cnt <= div_cnt + 4'd1;
            q_r     <= {q_r[6:0], ge_r};
            q_g     <= {q_g[6:0], ge_g};
            q_b     <= {q_b[6:0], ge_b};
            if (ge_r) acc_r <= acc_r - divisor[ACC_W-1:0];
            if (ge_g) acc_g <= acc_g - divisor[ACC_W-1:0];
            if (ge_b) acc_b <= acc_b - divisor[ACC_W-1:0];
          end
        end

        ST_OUT: begin
          if (led_ready) begin
            state     <= ST_ACCUM;
            led_valid <= 1'b0;
            pix_ready <= 1'b1;
            acc_r     <= '0;
            acc_g     <= '0;
            acc_b     <= '0;
            wsum      <= '0;
          end
        end

        default: begin
          state     <= ST_ACCUM;
          pix_ready <= 1'b1;
          led_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_area_led_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_area_led_accum
// Purpose  : Self-checking bench for area_led_accum; directed frames plus
//            random frames compared against a weighted-mean reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_area_led_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [23:0] pix_data = 24'h0;
  logic        judge1 = 1'b0;
  logic        judge2 = 1'b0;
  logic        judge3 = 1'b0;
  logic        frame_end = 1'b0;
  logic        led_valid;
  logic        led_ready = 1'b0;
  logic [23:0] led_rgb;
  logic        zero_area;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: running weighted sums of the open frame
  int unsigned sr = 0, sg = 0, sb = 0, sw = 0;
  logic [23:0] last_rgb = 24'h0;

  area_led_accum dut (
    .clk       (clk),
    .rst       (rst),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .judge1    (judge1),
    .judge2    (judge2),
    .judge3    (judge3),
    .frame_end (frame_end),
    .led_valid (led_valid),
    .led_ready (led_ready),
    .led_rgb   (led_rgb),
    .zero_area (zero_area)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned weight_of(input logic j1, input logic j2, input logic j3);
    if (j1) return 4;
    if (j2) return 2;
    if (j3) return 1;
    return 0;
  endfunction

  function automatic logic [23:0] expected_rgb();
    logic [7:0] r, g, b;
    if (sw == 0) begin
`ifdef AREA_LED_HOLD_EN
      return last_rgb;
`else
      return 24'h000000;
`endif
    end
    r = 8'(sr / sw);
    g = 8'(sg / sw);
    b = 8'(sb / sw);
    return {r, g, b};
  endfunction

  task automatic model_clear();
    sr = 0; sg = 0; sb = 0; sw = 0;
  endtask

  // Present one block for one cycle; frame_end optionally on the same cycle
  task automatic send(input logic [23:0] d, input logic j1, input logic j2,
                      input logic j3, input logic fe, input bit chk);
    int unsigned w;
    if (chk) check("pix_ready_accum", 32'(pix_ready), 32'd1);
    pix_data  = d;
    judge1    = j1;
    judge2    = j2;
    judge3    = j3;
    pix_valid = 1'b1;
    frame_end = fe;
    tick();
    pix_valid = 1'b0;
    frame_end = 1'b0;
    judge1 = 1'b0; judge2 = 1'b0; judge3 = 1'b0;
    w  = weight_of(j1, j2, j3);
    sr += w * d[23:16];
    sg += w * d[15:8];
    sb += w * d[7:0];
    sw += w;
  endtask

  // Called just after the edge that sampled frame_end; checks the result,
  // optionally stalls with junk traffic, then completes the handshake
  task automatic finish_frame(input int stall);
    int n;
    logic [23:0] exp_rgb;
    exp_rgb = expected_rgb();
    n = 0;
    while (led_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'd9);
    check("led_rgb", 32'(led_rgb), 32'(exp_rgb));
    check("zero_area", 32'(zero_area), (sw == 0) ? 32'd1 : 32'd0);
    check("pix_ready_out", 32'(pix_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      pix_valid = 1'b1;
      pix_data  = 24'($urandom);
      judge1    = 1'b1;
      frame_end = 1'($urandom);
      led_ready = 1'b0;
      tick();
      check("stall_rgb", 32'(led_rgb), 32'(exp_rgb));
      check("stall_pix_ready", 32'(pix_ready), 32'd0);
      check("stall_valid", 32'(led_valid), 32'd1);
    end
    pix_valid = 1'b0;
    frame_end = 1'b0;
    judge1    = 1'b0;
    led_ready = 1'b1;
    tick();
    led_ready = 1'b0;
    check("valid_drop", 32'(led_valid), 32'd0);
    check("pix_ready_back", 32'(pix_ready), 32'd1);
    last_rgb = exp_rgb;
    model_clear();
  endtask

  task automatic close_frame(input int stall);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    finish_frame(stall);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(led_valid), 32'd0);
    check("rst_ready", 32'(pix_ready), 32'd1);
    check("rst_rgb", 32'(led_rgb), 32'd0);
    check("rst_zero", 32'(zero_area), 32'd0);
    rst = 1'b0;
    tick();

    // 1: reset mid-frame, then single centre block
    send(24'h112233, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send(24'h445566, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_clear();
    last_rgb = 24'h0;
    tick();
    send(24'h804020, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    finish_frame(0);

    // 2: mixed weights, R only
    send(24'hC80000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send(24'h320000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    send(24'h0A0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    close_frame(0);
    check("t2_rgb", 32'(last_rgb), 32'h820000);

    // 3: all judges set -> W1; then a frame of zero-weight blocks
    send(24'h0A0A0A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    finish_frame(0);
    send(24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(24'h777777, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    close_frame(0);

    // 4: long stall in OUT with junk traffic, then a clean frame
    send(24'h204060, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    finish_frame(20);
    send(24'h102030, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    finish_frame(0);

    // 5: reset during DIV
    send(24'h123456, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("div_rst_valid", 32'(led_valid), 32'd0);
    check("div_rst_ready", 32'(pix_ready), 32'd1);
    check("div_rst_rgb", 32'(led_rgb), 32'd0);
    check("div_rst_zero", 32'(zero_area), 32'd0);
    #2;
    rst = 1'b0;
    model_clear();
    last_rgb = 24'h0;
    tick();
    send(24'hFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    finish_frame(0);

    // Random frames against the weighted-mean model
    for (int f = 0; f < 30; f++) begin
      int np;
      np = $urandom_range(0, 24);
      for (int p = 0; p < np; p++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send(24'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             (p == np - 1) && ($urandom_range(0, 1) == 1), 1'b0);
        if (led_valid === 1'b1 || pix_ready === 1'b0) break;
      end
      if (pix_ready === 1'b0) finish_frame($urandom_range(0, 3));
      else close_frame($urandom_range(0, 3));
    end

    // 6: full 128x128 area at maximum value, then an empty frame
    for (int p = 0; p < 16384; p++)
      send(24'hFFFFFF, 1'b1, 1'b0, 1'b0, (p == 16383), 1'b0);
    finish_frame(0);
    check("t6_rgb", 32'(last_rgb), 32'hFFFFFF);
    close_frame(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
